reg_read: RTL and testbench

Register-read stage of the RISC-V pipeline: it owns the 32-entry integer register file and reads it. The write side of the file is driven by the writeback stage; this block serves decoded instructions with two source operands and feeds one registered operand packet to execute over a valid/ready handshake. A per-register scoreboard stalls read-after-write and write-after-write hazards until the pending writeback lands. Same-cycle writeback data is bypassed.

---
 rtl/reg_read.sv | 102 ++++++++++
 tb/tb_reg_read.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_read.sv
// Register-read stage: owns the integer register file, tracks pending writes
// in a per-register scoreboard and hands one operand packet to execute.
module reg_read #(
    parameter int LOGSIZE = 64,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [REGBITS-1:0] in_rs1,
    input  logic [REGBITS-1:0] in_rs2,
    input  logic [REGBITS-1:0] in_rd,
    input  logic               in_rd_we,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LOGSIZE-1:0] out_rs1_val,
    output logic [LOGSIZE-1:0] out_rs2_val,
    output logic [REGBITS-1:0] out_rd,
    output logic               out_rd_we,
    input  logic               wb_en,
    input  logic [REGBITS-1:0] wb_rd,
    input  logic [LOGSIZE-1:0] wb_data,
    input  logic               flush
);

    localparam int NREG = 1 << REGBITS;

    logic [LOGSIZE-1:0] rf [NREG];
    logic [NREG-1:0]    busy;
    logic [NREG-1:0]    busy_next;
    logic [NREG-1:0]    wb_mask;
    logic [NREG-1:0]    busy_eff;
    logic [LOGSIZE-1:0] rs1_val;
    logic [LOGSIZE-1:0] rs2_val;
    logic               rd_we_g;
    logic               hazard;
    logic               accept;

    always_comb begin
        wb_mask = '0;
        if (wb_en) wb_mask[wb_rd] = 1'b1;
    end

    // A pending write whose writeback is on the bus this cycle no longer blocks.
    assign busy_eff = busy & ~wb_mask;

    always_comb begin
        rs1_val = rf[in_rs1];
        if (in_rs1 == '0)
            rs1_val = '0;
        else if (wb_en && wb_rd == in_rs1)
            rs1_val = wb_data;
    end

    always_comb begin
        rs2_val = rf[in_rs2];
        if (in_rs2 == '0)
            rs2_val = '0;
        else if (wb_en && wb_rd == in_rs2)
            rs2_val = wb_data;
    end

    assign rd_we_g  = in_rd_we && (in_rd != '0);
    assign hazard   = in_valid && (busy_eff[in_rs1] || busy_eff[in_rs2] ||
                                   (in_rd_we && busy_eff[in_rd]));
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // Order matters: writeback clear, then flush clear, then accept set wins.
    always_comb begin
        busy_next = busy & ~wb_mask;
        if (flush && out_valid && out_rd_we) busy_next[out_rd] = 1'b0;
        if (accept && rd_we_g) busy_next[in_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            busy        <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (wb_en && wb_rd != '0) rf[wb_rd] <= wb_data;
            busy <= busy_next;
            if (accept) begin
                out_valid   <= 1'b1;
                out_rs1_val <= rs1_val;
                out_rs2_val <= rs2_val;
                out_rd      <= in_rd;
                out_rd_we   <= rd_we_g;
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_read.sv
// Bench for reg_read: table of vectors plus hand sequences for hazards,
// backpressure, flush and reset; packets are checked through a scoreboard.
module tb_reg_read;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_we;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;

    reg_read #(.LOGSIZE(64), .REGBITS(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_we(out_rd_we),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        we;
    } pkt_t;

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic        wbe;
        logic [4:0]  wbr;
        logic [63:0] wbd;
        logic        rdy;
    } vec_t;

    pkt_t        sb_q[$];
    logic [63:0] sh_rf [32];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_read(input logic [4:0] idx, input logic wbe,
                                             input logic [4:0] wbr, input logic [63:0] wbd);
        if (idx == 5'd0) return 64'd0;
        if (wbe && wbr == idx) return wbd;
        return sh_rf[idx];
    endfunction

    // Drive one cycle of inputs, check in_ready, push the expected packet on accept.
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic wbe,
                        input logic [4:0] wbr, input logic [63:0] wbd,
                        input logic exp_rdy, input string name);
        pkt_t p;
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
        wb_en = wbe; wb_rd = wbr; wb_data = wbd;
        #1;
        check({name, "_ready"}, {63'd0, in_ready}, {63'd0, exp_rdy});
        if (v && in_ready) begin
            p.a  = ref_read(rs1, wbe, wbr, wbd);
            p.b  = ref_read(rs2, wbe, wbr, wbd);
            p.rd = rd;
            p.we = we && (rd != 5'd0);
            sb_q.push_back(p);
        end
        @(posedge clk);
        if (wbe && wbr != 5'd0) sh_rf[wbr] = wbd;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, "idle");
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_packet", {63'd0, out_valid}, 64'd0);
            end else begin
                pkt_t e;
                e = sb_q.pop_front();
                check("sb_rs1", out_rs1_val, e.a);
                check("sb_rs2", out_rs2_val, e.b);
                check("sb_rd", {59'd0, out_rd}, {59'd0, e.rd});
                check("sb_rd_we", {63'd0, out_rd_we}, {63'd0, e.we});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl [7];

    initial begin
        for (int i = 0; i < 32; i++) sh_rf[i] = 64'd0;
        rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
        out_ready = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_rs1", out_rs1_val, 64'd0);
        check("rst_rd", {59'd0, out_rd}, 64'd0);

        //        v     rs1   rs2   rd    we    wbe   wbr   wbd          rdy
        tbl[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 64'h1234, 1'b1};
        tbl[1] = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 64'h0,    1'b1};
        tbl[2] = '{1'b1, 5'd1, 5'd5, 5'd4, 1'b0, 1'b1, 5'd1, 64'h11,   1'b1};
        tbl[3] = '{1'b1, 5'd2, 5'd1, 5'd0, 1'b1, 1'b1, 5'd2, 64'h22,   1'b1};
        tbl[4] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 64'hFF,   1'b1};
        tbl[5] = '{1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 64'h0,    1'b1};
        tbl[6] = '{1'b1, 5'd3, 5'd3, 5'd6, 1'b0, 1'b1, 5'd3, 64'h33,   1'b1};
        for (int i = 0; i < 7; i++)
            step(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we,
                 tbl[i].wbe, tbl[i].wbr, tbl[i].wbd, tbl[i].rdy, $sformatf("tbl%0d", i));

        // RAW on x7, released by the same-cycle writeback
        step(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1, "raw_prod");
        step(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, "raw_stall0");
        step(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, "raw_stall1");
        step(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 1'b1, 5'd7, 64'hAB, 1'b1, "raw_bypass");
        check("raw_out_rs1", out_rs1_val, 64'hAB);

        // WAW on x3: the re-set wins over the coinciding writeback clear
        step(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1, "waw_prod");
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, "waw_stall");
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd3, 64'h44, 1'b1, "waw_accept");
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, "waw_still_busy");
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 64'h55, 1'b1, "waw_release");
        idle();

        // Backpressure: held packet stays stable for 3 cycles
        out_ready = 1'b0;
        step(1'b1, 5'd1, 5'd2, 5'd10, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, "bp_first");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd2, 5'd1, 5'd12, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, "bp_hold");
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_rs1", out_rs1_val, 64'h11);
            check("bp_rs2", out_rs2_val, 64'h22);
            check("bp_rd", {59'd0, out_rd}, 64'd10);
        end
        out_ready = 1'b1;
        step(1'b1, 5'd2, 5'd1, 5'd12, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, "bp_release");
        check("bp_next_rd", {59'd0, out_rd}, 64'd12);
        check("bp_next_valid", {63'd0, out_valid}, 64'd1);
        idle();

        // Flush of a held packet with a pending x9 write
        out_ready = 1'b0;
        step(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1, "fl_prod");
        flush = 1'b1;
        void'(sb_q.pop_back());
        step(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, "fl_during");
        flush = 1'b0;
        check("fl_out_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        step(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, "fl_after");
        idle();

        // Reset in the middle of a stall on x11
        out_ready = 1'b0;
        step(1'b1, 5'd5, 5'd0, 5'd11, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1, "rs_prod");
        step(1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, "rs_stall");
        rst = 1'b1;
        void'(sb_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) sh_rf[i] = 64'd0;
        check("rs_out_valid", {63'd0, out_valid}, 64'd0);
        check("rs_out_rs1", out_rs1_val, 64'd0);
        check("rs_out_rd", {59'd0, out_rd}, 64'd0);
        check("rs_out_rd_we", {63'd0, out_rd_we}, 64'd0);
        out_ready = 1'b1;
        step(1'b1, 5'd11, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, "rs_after");
        idle();
        idle();

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
